seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Shares the single 8-bit seven-segment display (SEG) among NREQ requesters, each presenting a 3-bit two's-complement integer. A round-robin arbiter grants one requester at a time. The granted value is latched, encoded to segments with SEG[7] (the dot) standing in for the minus sign, and held for HOLD_CYCLES. A blank gap follows each slot. The block sits in `top` between the operand/result sources and the SEG output.

## Interface
- NREQ, 2, number of requesters (≥2)
- HOLD_CYCLES, 4, cycles each granted value stays on SEG (≥1)
- CNT_W, $clog2(HOLD_CYCLES+1), hold counter width (derived, not overridden)
- clk_2  in  1  single system clock, rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- req  in  NREQ  request per requester; level, held until its done pulse
- val  in  [NREQ-1:0][2:0]  signed value per requester; sampled only at grant
- gnt  out  NREQ  one-hot grant; high for the whole display slot
- done  out  NREQ  one-cycle pulse to the granted requester at slot end
- busy  out  1  high whenever state ≠ IDLE
- SEG  out  8  SEG[6:0] = segments a..g (active-high), SEG[7] = minus sign

## Operation
- Reset values: state = IDLE, SEG = 8'h00, gnt = 0, done = 0, busy = 0, rr_ptr = 0, cnt = 0.
- States: IDLE, SHOW, GAP.
- IDLE, with no req: stay in IDLE.
- IDLE, with any req: grant the first asserted req scanning from rr_ptr upward (mod NREQ).
  - Load gnt with the one-hot grant.
  - Latch the encoded val into SEG.
  - Set cnt = HOLD_CYCLES-1 and go to SHOW.
- SHOW, cnt ≠ 0: decrement cnt. SEG and gnt stay stable.
- SHOW, cnt == 0 (slot end):
  - Pulse done[g] for one cycle.
  - Clear gnt and SEG to 0.
  - Set rr_ptr = (g+1) mod NREQ and go to GAP.
- GAP: lasts exactly one cycle, with SEG blank.
  - req[g] of the just-finished requester is masked.
  - Another req pending: arbitrate as in IDLE and go straight to SHOW.
  - No other req pending: go to IDLE.
- Encoding of val (hex SEG):
  - 0→3F, 1→06, 2→5B, 3→4F
  - −1→86, −2→DB, −3→CF, −4→E6
  - Negative values show the magnitude digit with SEG[7] = 1.
- val changing during SHOW has no effect; the latched pattern is displayed.
- req dropping during SHOW does not abort the slot; done still pulses.
- A requester that holds req after its done pulse is re-granted in a later slot, once the others have been served, per round-robin.
- Reset asserted mid-slot: all outputs go to reset values immediately. No done pulse is issued and the slot is lost.

## Timing
- Grant latency: req sampled high in IDLE at edge k → gnt, SEG and busy valid after edge k.
- SEG shows the pattern for exactly HOLD_CYCLES cycles, then is blank for at least 1 cycle.
- done is asserted in the cycle after the last display cycle, coincident with the first GAP cycle.
- Back-to-back throughput: one grant per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES = 1: SHOW lasts one cycle, and done follows on the next edge.
- All outputs are registered; there are no combinational paths from req or val to any output.

## Structure
- Package seg_display_pkg:
  - state enum {IDLE, SHOW, GAP}
  - localparam segment patterns DIG0..DIG4 and SEG_MINUS = 8'h80
- Sub-module int3_to_seg: combinational encoder, 3-bit signed input → 8-bit SEG pattern, instantiated once on the muxed granted value.
- The round-robin pick is a function inside the arbiter, not a separate module.

## Test plan
- Reset: reset_n low with req = 2'b11 → SEG = 00, gnt = 0, busy = 0. Release reset with req[0] = 1, val[0] = 3'b010 → after the next edge SEG = 5B and gnt = 01 for 4 cycles, then done[0] pulses and SEG = 00.
- Encoding sweep: single requester drives all 8 values → SEG sequence 3F, 06, 5B, 4F, E6, CF, DB, 86 for val 0, 1, 2, 3, −4, −3, −2, −1.
- Fairness: req = 2'b11 held continuously → gnt alternates 01, 10, 01, …; each slot lasts 4 cycles, separated by a 1-cycle blank; period 5 cycles.
- Stability: val[1] toggled and req[1] dropped mid-SHOW → SEG unchanged for all 4 cycles and done[1] still pulses.
- Reset mid-slot: reset_n pulsed low at cycle 2 of SHOW → SEG, gnt, done and busy go to 0 asynchronously. No done pulse; after reset, arbitration restarts from requester 0.
- HOLD_CYCLES = 1 build: req[1] only → gnt = 10 for 1 cycle, done[1] on the next cycle, GAP, then IDLE with busy = 0.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and segment patterns for the seven-segment display arbiter.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Active-high a..g in bits 6:0
  localparam logic [7:0] DIG0      = 8'h3F;
  localparam logic [7:0] DIG1      = 8'h06;
  localparam logic [7:0] DIG2      = 8'h5B;
  localparam logic [7:0] DIG3      = 8'h4F;
  localparam logic [7:0] DIG4      = 8'h66;
  localparam logic [7:0] SEG_MINUS = 8'h80;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle of the display arbiter: level requests, values, grant/done and the SEG bus.
interface seg_display_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0][2:0] val;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [7:0]           SEG;

  modport master (
    output req, val,
    input  gnt, done, busy, SEG
  );

  modport slave (
    input  req, val,
    output gnt, done, busy, SEG
  );

endinterface

// File: rtl/seg_display_arbiter_int3_to_seg.sv
// Combinational 3-bit two's-complement to seven-segment encoder; zero latency, no flow control.
module int3_to_seg
  import seg_display_pkg::*;
(
  input  logic [2:0] val,
  output logic [7:0] seg
);

  // Negative values show the magnitude digit with the dot lit as a minus sign
  always_comb begin
    seg = 8'h00;
    case (val)
      3'b000: seg = DIG0;
      3'b001: seg = DIG1;
      3'b010: seg = DIG2;
      3'b011: seg = DIG3;
      3'b100: seg = SEG_MINUS | DIG4;
      3'b101: seg = SEG_MINUS | DIG3;
      3'b110: seg = SEG_MINUS | DIG2;
      3'b111: seg = SEG_MINUS | DIG1;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin share of one SEG display: grant visible one edge after req, held HOLD_CYCLES, then 1-cycle blank.
// Requesters wait on level req until their done pulse; a dropped req never aborts a running slot.
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  seg_display_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = $clog2(NREQ);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [7:0]          seg_q, seg_d;
  logic                busy_q;

  logic [NREQ-1:0]     req_eff;
  logic [IDX_W:0]      pick;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [2:0]          pick_val;
  logic [7:0]          pick_seg;

  // First asserted request at or after ptr, wrapping; MSB flags a hit
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             j;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (r[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  // The requester that just finished sits out the gap cycle
  always_comb begin
    req_eff = bus.req;
    if (state_q == GAP) req_eff[cur_q] = 1'b0;
  end

  assign pick     = rr_pick(req_eff, rr_ptr_q);
  assign pick_vld = pick[IDX_W];
  assign pick_idx = pick[IDX_W-1:0];
  assign pick_val = bus.val[pick_idx];

  int3_to_seg u_enc (
    .val (pick_val),
    .seg (pick_seg)
  );

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      cur_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      seg_q    <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      cur_q    <= cur_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      seg_q    <= seg_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = SHOW;
      SHOW:    if (cnt_q == '0) state_d = GAP;
      GAP:     state_d = pick_vld ? SHOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    cur_d    = cur_q;
    gnt_d    = gnt_q;
    seg_d    = seg_q;
    done_d   = '0;
    case (state_q)
      IDLE, GAP: begin
        gnt_d = '0;
        seg_d = 8'h00;
        if (pick_vld) begin
          gnt_d[pick_idx] = 1'b1;
          seg_d           = pick_seg;
          cnt_d           = CNT_W'(HOLD_CYCLES - 1);
          cur_d           = pick_idx;
        end
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done_d[cur_q] = 1'b1;
          gnt_d         = '0;
          seg_d         = 8'h00;
          rr_ptr_d      = (cur_q == IDX_W'(NREQ - 1)) ? '0 : cur_q + IDX_W'(1);
        end
      end
      default: begin
        gnt_d = '0;
        seg_d = 8'h00;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.SEG  = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed + random checks of seg_display_arbiter (HOLD_CYCLES=4 and =1 builds) against a slot-timeline model.
module tb_seg_display_arbiter;

  logic clk_2   = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;

  seg_display_arbiter_if #(.NREQ(2)) ifa ();
  seg_display_arbiter_if #(.NREQ(2)) ifb ();

  seg_display_arbiter #(.NREQ(2), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (ifa.slave)
  );

  seg_display_arbiter #(.NREQ(2), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (ifb.slave)
  );

  always #5 clk_2 = ~clk_2;

  // Model: each display slot is "left" cycles of pattern followed by one gap cycle
  int         m_left  [2];
  int         m_owner [2];
  bit         m_gap   [2];
  int         m_ptr   [2];
  logic [7:0] m_pat   [2];
  logic [1:0] m_done  [2];

  function automatic logic [7:0] ref_enc(input logic [2:0] v);
    logic [7:0] dig [5];
    int s, mag;
    dig = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};
    s   = v[2] ? int'(v) - 8 : int'(v);
    mag = (s < 0) ? -s : s;
    return ((s < 0) ? 8'h80 : 8'h00) | dig[mag];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_owner[d] = 0; m_gap[d] = 1'b0;
      m_ptr[d] = 0; m_pat[d] = 8'h00; m_done[d] = 2'b00;
    end
  endtask

  task automatic model_step(input int d, input logic [1:0] r,
                            input logic [1:0][2:0] v, input int hold);
    logic [1:0] cand;
    bit found;
    int j;
    m_done[d] = 2'b00;
    if (m_left[d] > 1) begin
      m_left[d]--;
    end else if (m_left[d] == 1) begin
      m_left[d] = 0;
      m_gap[d]  = 1'b1;
      m_done[d] = 2'(1 << m_owner[d]);
      m_ptr[d]  = (m_owner[d] + 1) % 2;
    end else begin
      cand = r;
      if (m_gap[d]) cand[m_owner[d]] = 1'b0;
      m_gap[d] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2; i++) begin
        j = (m_ptr[d] + i) % 2;
        if (!found && cand[j]) begin
          found      = 1'b1;
          m_left[d]  = hold;
          m_owner[d] = j;
          m_pat[d]   = ref_enc(v[j]);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input int d, input logic [1:0] g, input logic [1:0] dn,
                           input logic b, input logic [7:0] s);
    logic [1:0] eg;
    eg = (m_left[d] > 0) ? 2'(1 << m_owner[d]) : 2'b00;
    chk($sformatf("m%0d_gnt", d),  {6'b0, g},  {6'b0, eg});
    chk($sformatf("m%0d_done", d), {6'b0, dn}, {6'b0, m_done[d]});
    chk($sformatf("m%0d_busy", d), {7'b0, b},  {7'b0, (m_left[d] > 0) || m_gap[d]});
    chk($sformatf("m%0d_seg", d),  s, (m_left[d] > 0) ? m_pat[d] : 8'h00);
  endtask

  // One clock: model sees the inputs the DUT samples, outputs checked at the falling edge
  task automatic tick();
    @(posedge clk_2);
    if (!reset_n) begin
      model_reset();
    end else begin
      model_step(0, ifa.req, ifa.val, HOLD_A);
      model_step(1, ifb.req, ifb.val, HOLD_B);
    end
    @(negedge clk_2);
    chk_model(0, ifa.gnt, ifa.done, ifa.busy, ifa.SEG);
    chk_model(1, ifb.gnt, ifb.done, ifb.busy, ifb.SEG);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 20; i++) begin
      if (m_left[0] == 0 && !m_gap[0]) break;
      tick();
    end
    chk("idle_busy_a", {7'b0, ifa.busy}, 8'h00);
  endtask

  initial begin : stim
    logic [7:0] sweep_exp [8];
    logic [2:0] sweep_val [8];
    logic [1:0] exp_g;
    bit seen;
    sweep_val = '{3'd0, 3'd1, 3'd2, 3'd3, 3'b100, 3'b101, 3'b110, 3'b111};
    sweep_exp = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'hE6, 8'hCF, 8'hDB, 8'h86};

    model_reset();
    ifa.req = 2'b11; ifa.val = '0;
    ifb.req = 2'b11; ifb.val = '0;

    // Reset holds everything quiet even with requests pending
    repeat (3) @(negedge clk_2);
    chk("rst_seg",  ifa.SEG, 8'h00);
    chk("rst_gnt",  {6'b0, ifa.gnt}, 8'h00);
    chk("rst_busy", {7'b0, ifa.busy}, 8'h00);
    chk("rst_done", {6'b0, ifa.done}, 8'h00);

    // First transaction
    reset_n = 1'b1;
    ifa.req = 2'b01; ifa.val[0] = 3'b010;
    ifb.req = 2'b00;
    tick();
    chk("first_seg", ifa.SEG, 8'h5B);
    chk("first_gnt", {6'b0, ifa.gnt}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("first_hold", ifa.SEG, 8'h5B);
    end
    tick();
    chk("first_done", {6'b0, ifa.done}, 8'h01);
    chk("first_blank", ifa.SEG, 8'h00);
    ifa.req = 2'b00;
    tick();
    chk("first_idle", {7'b0, ifa.busy}, 8'h00);

    // Encoding sweep on requester 0
    for (int k = 0; k < 8; k++) begin
      ifa.req = 2'b01; ifa.val[0] = sweep_val[k];
      tick();
      chk($sformatf("enc_%0d", k), ifa.SEG, sweep_exp[k]);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        seen = ifa.done[0];
      end
      chk("enc_done_seen", {7'b0, seen}, 8'h01);
      ifa.req = 2'b00;
      tick();
    end

    // Fairness: last grant was requester 0, so requester 1 goes first
    ifa.req = 2'b11;
    for (int t = 0; t < 20; t++) begin
      ifa.val = 6'($urandom);
      tick();
      if (t % 5 == 4) exp_g = 2'b00;
      else exp_g = ((t / 5) % 2 == 0) ? 2'b10 : 2'b01;
      chk("fair_gnt", {6'b0, ifa.gnt}, {6'b0, exp_g});
    end
    ifa.req = 2'b00;
    wait_idle_a();

    // Stability: val wiggles and req drops mid-slot
    ifa.req = 2'b10; ifa.val[1] = 3'b011;
    tick();
    chk("stab_seg0", ifa.SEG, 8'h4F);
    for (int i = 0; i < 3; i++) begin
      ifa.val[1] = 3'($urandom);
      if (i == 0) ifa.req = 2'b00;
      tick();
      chk("stab_seg", ifa.SEG, 8'h4F);
      chk("stab_gnt", {6'b0, ifa.gnt}, 8'h02);
    end
    tick();
    chk("stab_done", {6'b0, ifa.done}, 8'h02);
    wait_idle_a();

    // Reset mid-slot: requester 1 in SHOW, then reset restarts arbitration at 0
    ifa.req = 2'b10; ifa.val[1] = 3'b001;
    tick();
    tick();
    chk("mid_gnt_pre", {6'b0, ifa.gnt}, 8'h02);
    ifa.req = 2'b11;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_seg",  ifa.SEG, 8'h00);
    chk("mid_rst_gnt",  {6'b0, ifa.gnt}, 8'h00);
    chk("mid_rst_done", {6'b0, ifa.done}, 8'h00);
    chk("mid_rst_busy", {7'b0, ifa.busy}, 8'h00);
    model_reset();
    @(negedge clk_2);
    reset_n = 1'b1;
    tick();
    chk("mid_restart_gnt", {6'b0, ifa.gnt}, 8'h01);
    ifa.req = 2'b00;
    wait_idle_a();

    // HOLD_CYCLES = 1 build
    ifb.req = 2'b10; ifb.val = 6'($urandom);
    tick();
    chk("h1_gnt",  {6'b0, ifb.gnt}, 8'h02);
    chk("h1_busy", {7'b0, ifb.busy}, 8'h01);
    tick();
    chk("h1_gnt_off", {6'b0, ifb.gnt}, 8'h00);
    chk("h1_done",    {6'b0, ifb.done}, 8'h02);
    ifb.req = 2'b00;
    tick();
    chk("h1_idle", {7'b0, ifb.busy}, 8'h00);
    chk("h1_done_off", {6'b0, ifb.done}, 8'h00);

    // Random traffic on both builds
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!ifa.req[r]) ifa.req[r] = ($urandom_range(2) == 0);
        else if (ifa.done[r]) ifa.req[r] = $urandom_range(1) == 0;
        else if (ifa.gnt[r] && $urandom_range(7) == 0) ifa.req[r] = 1'b0;
        if (!ifb.req[r]) ifb.req[r] = ($urandom_range(2) == 0);
        else if (ifb.done[r]) ifb.req[r] = $urandom_range(1) == 0;
      end
      ifa.val = 6'($urandom);
      ifb.val = 6'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
